// File: rtl/uart_echo_checker.sv
// Host-side UART echo checker: sends a pattern, checks each echo == sent+INCREMENT, counts pass/fail/timeout.
// Pattern source: incrementing counter, or 8-bit LFSR when UART_ECHO_CHECK_LFSR_EN is defined; tx_valid holds until tx_ready.
module uart_echo_checker #(
   parameter int unsigned NUM_BYTES      = 256,
   parameter logic [7:0]  SEED           = 8'h00,
   parameter logic [7:0]  INCREMENT      = 8'h01,
   parameter int unsigned TIMEOUT_CYCLES = 100000,
   parameter int unsigned GAP_CYCLES     = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   output logic [7:0]  tx_data_o,
   output logic        tx_valid_o,
   input  logic        tx_ready_i,
   input  logic [7:0]  rx_data_i,
   input  logic        rx_valid_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [15:0] pass_count_o,
   output logic [15:0] fail_count_o,
   output logic [15:0] tout_count_o,
   output logic [7:0]  last_sent_o,
   output logic [7:0]  last_rcvd_o
);

   typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_GAP, S_DONE} state_t;

`ifdef UART_ECHO_CHECK_LFSR_EN
   // An all-zero LFSR state never leaves zero, so a zero seed is bumped to 1.
   localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
   function automatic logic [7:0] next_pat(input logic [7:0] p);
      return {p[6:0], p[7] ^ p[5] ^ p[4] ^ p[3]};
   endfunction
`else
   localparam logic [7:0] SEED_EFF = SEED;
   function automatic logic [7:0] next_pat(input logic [7:0] p);
      return p + 8'h01;
   endfunction
`endif

   localparam logic [31:0] TOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0] GAP_LAST  = (GAP_CYCLES == 0) ? 32'd0 : 32'(GAP_CYCLES - 1);
   localparam logic [15:0] NUM16     = 16'(NUM_BYTES);

   function automatic logic [15:0] sat_inc(input logic [15:0] x);
      return (x == 16'hFFFF) ? x : x + 16'd1;
   endfunction

   state_t      state_q, state_d;
   logic [7:0]  pattern_q, pattern_d;
   logic [15:0] index_q, index_d;
   logic [31:0] timer_q, timer_d;
   logic [15:0] pass_q, pass_d, fail_q, fail_d, tout_q, tout_d;
   logic [7:0]  last_sent_q, last_sent_d, last_rcvd_q, last_rcvd_d;
   logic        tx_valid_q, tx_valid_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic [7:0]  expect_w;

   assign expect_w = pattern_q + INCREMENT;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         pattern_q   <= SEED_EFF;
         index_q     <= 16'd0;
         timer_q     <= 32'd0;
         pass_q      <= 16'd0;
         fail_q      <= 16'd0;
         tout_q      <= 16'd0;
         last_sent_q <= 8'd0;
         last_rcvd_q <= 8'd0;
         tx_valid_q  <= 1'b0;
         tx_data_q   <= 8'd0;
      end else begin
         state_q     <= state_d;
         pattern_q   <= pattern_d;
         index_q     <= index_d;
         timer_q     <= timer_d;
         pass_q      <= pass_d;
         fail_q      <= fail_d;
         tout_q      <= tout_d;
         last_sent_q <= last_sent_d;
         last_rcvd_q <= last_rcvd_d;
         tx_valid_q  <= tx_valid_d;
         tx_data_q   <= tx_data_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pattern_d   = pattern_q;
      index_d     = index_q;
      timer_d     = timer_q;
      pass_d      = pass_q;
      fail_d      = fail_q;
      tout_d      = tout_q;
      last_sent_d = last_sent_q;
      last_rcvd_d = last_rcvd_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               pass_d      = 16'd0;
               fail_d      = 16'd0;
               tout_d      = 16'd0;
               last_sent_d = 8'd0;
               last_rcvd_d = 8'd0;
               pattern_d   = SEED_EFF;
               index_d     = 16'd0;
               state_d     = S_SEND;
            end
         end
         S_SEND: begin
            if (tx_valid_q && tx_ready_i) begin
               last_sent_d = pattern_q;
               timer_d     = 32'd0;
               state_d     = S_WAIT;
            end
         end
         S_WAIT: begin
            timer_d = timer_q + 32'd1;
            // A response landing on the last allowed cycle wins over the timeout.
            if (rx_valid_i) begin
               last_rcvd_d = rx_data_i;
               if (rx_data_i == expect_w) pass_d = sat_inc(pass_q);
               else                       fail_d = sat_inc(fail_q);
               timer_d = 32'd0;
               state_d = S_GAP;
            end else if (timer_q == TOUT_LAST) begin
               tout_d  = sat_inc(tout_q);
               timer_d = 32'd0;
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            timer_d = timer_q + 32'd1;
            if (timer_q >= GAP_LAST) begin
               pattern_d = next_pat(pattern_q);
               index_d   = index_q + 16'd1;
               state_d   = (index_q + 16'd1 == NUM16) ? S_DONE : S_SEND;
            end
         end
         default: state_d = S_IDLE;
      endcase
      tx_valid_d = (state_d == S_SEND);
      tx_data_d  = tx_valid_d ? pattern_d : 8'd0;
   end

   assign tx_valid_o   = tx_valid_q;
   assign tx_data_o    = tx_data_q;
   assign busy_o       = (state_q == S_SEND) || (state_q == S_WAIT) || (state_q == S_GAP);
   assign done_o       = (state_q == S_DONE);
   assign pass_count_o = pass_q;
   assign fail_count_o = fail_q;
   assign tout_count_o = tout_q;
   assign last_sent_o  = last_sent_q;
   assign last_rcvd_o  = last_rcvd_q;

endmodule

// File: tb/tb_uart_echo_checker.sv
// Directed bench for uart_echo_checker with a behavioural echo responder (configurable delay / corruption).
module tb_uart_echo_checker;

`ifdef UART_ECHO_CHECK_LFSR_EN
   localparam logic [7:0] TB_SEED = 8'h00;
`else
   localparam logic [7:0] TB_SEED = 8'hFE;
`endif

   logic        clk_i = 1'b0;
   logic        rst_i, start_i, tx_ready_i, rx_valid_i;
   logic [7:0]  rx_data_i, tx_data_o, last_sent_o, last_rcvd_o;
   logic        tx_valid_o, busy_o, done_o;
   logic [15:0] pass_count_o, fail_count_o, tout_count_o;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] exp_seq [4];
   logic [7:0] sent    [8];
   int         hs_cnt = 0;
   int         rx_cnt = 0;
   logic       echo_on = 1'b0;
   logic       bad3 = 1'b0;
   int         echo_dly = 50;

   always #5 clk_i = ~clk_i;

   uart_echo_checker #(
      .NUM_BYTES(4), .SEED(TB_SEED), .INCREMENT(8'h01),
      .TIMEOUT_CYCLES(100), .GAP_CYCLES(4)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
      .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
      .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
      .busy_o(busy_o), .done_o(done_o),
      .pass_count_o(pass_count_o), .fail_count_o(fail_count_o), .tout_count_o(tout_count_o),
      .last_sent_o(last_sent_o), .last_rcvd_o(last_rcvd_o)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk_i);
   endtask

   task automatic pulse_start();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 3000; i++) begin
         if (done_o) break;
         tick();
      end
      chk("done", {31'd0, done_o}, 32'd1);
   endtask

   task automatic wait_hs(input int n);
      for (int i = 0; i < 500; i++) begin
         if (hs_cnt >= n) break;
         tick();
      end
      chk("handshake_seen", (hs_cnt >= n) ? 32'd1 : 32'd0, 32'd1);
   endtask

   task automatic run(input logic on, input logic corrupt, input int dly);
      echo_on  = on;
      bad3     = corrupt;
      echo_dly = dly;
      hs_cnt   = 0;
      rx_cnt   = 0;
      pulse_start();
   endtask

   // Echo responder: watches handshakes just after each falling edge, replies after echo_dly cycles.
   initial begin
      logic [7:0] b;
      rx_valid_i = 1'b0;
      rx_data_i  = 8'd0;
      forever begin
         @(negedge clk_i);
         #1;
         if (tx_valid_o && tx_ready_i) begin
            if (hs_cnt < 8) sent[hs_cnt] = tx_data_o;
            hs_cnt++;
            if (echo_on) begin
               b = tx_data_o + ((bad3 && hs_cnt == 3) ? 8'h02 : 8'h01);
               repeat (echo_dly) @(negedge clk_i);
               #1;
               rx_data_i  = b;
               rx_valid_i = 1'b1;
               @(negedge clk_i);
               #1;
               rx_valid_i = 1'b0;
               rx_cnt++;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] e8;
      int bad_v, bad_d;
`ifdef UART_ECHO_CHECK_LFSR_EN
      exp_seq = '{8'h01, 8'h02, 8'h04, 8'h08};
`else
      exp_seq = '{8'hFE, 8'hFF, 8'h00, 8'h01};
`endif
      rst_i = 1'b1; start_i = 1'b0; tx_ready_i = 1'b1;
      repeat (3) tick();
      rst_i = 1'b0;
      tick();
      chk("rst_busy", {31'd0, busy_o}, 32'd0);
      chk("rst_done", {31'd0, done_o}, 32'd0);
      chk("rst_tx_valid", {31'd0, tx_valid_o}, 32'd0);
      chk("rst_tx_data", {24'd0, tx_data_o}, 32'd0);
      chk("rst_counts", {pass_count_o | fail_count_o | tout_count_o}, 32'd0);
      chk("rst_last", {16'd0, last_sent_o, last_rcvd_o}, 32'd0);

      // Ideal echo; start while busy must be ignored.
      run(1'b1, 1'b0, 50);
      chk("send_first_data", {24'd0, tx_data_o}, {24'd0, exp_seq[0]});
      wait_hs(1);
      chk("tx_valid_drop", {31'd0, tx_valid_o}, 32'd0);
      chk("busy_in_wait", {31'd0, busy_o}, 32'd1);
      repeat (20) tick();
      pulse_start();
      wait_done();
      chk("ideal_pass", {16'd0, pass_count_o}, 32'd4);
      chk("ideal_fail", {16'd0, fail_count_o}, 32'd0);
      chk("ideal_tout", {16'd0, tout_count_o}, 32'd0);
      chk("ideal_busy", {31'd0, busy_o}, 32'd0);
      chk("ideal_hs", hs_cnt, 32'd4);
      for (int i = 0; i < 4; i++) chk($sformatf("sent_%0d", i), {24'd0, sent[i]}, {24'd0, exp_seq[i]});
      chk("ideal_last_sent", {24'd0, last_sent_o}, {24'd0, exp_seq[3]});
      e8 = exp_seq[3] + 8'h01;
      chk("ideal_last_rcvd", {24'd0, last_rcvd_o}, {24'd0, e8});

      // Third echo corrupted by +2.
      run(1'b1, 1'b1, 50);
      for (int i = 0; i < 2000; i++) begin
         if (rx_cnt >= 3) break;
         tick();
      end
      tick();
      e8 = exp_seq[2] + 8'h02;
      chk("bad3_last_rcvd", {24'd0, last_rcvd_o}, {24'd0, e8});
      chk("bad3_fail_mid", {16'd0, fail_count_o}, 32'd1);
      wait_done();
      chk("bad3_pass", {16'd0, pass_count_o}, 32'd3);
      chk("bad3_fail", {16'd0, fail_count_o}, 32'd1);
      chk("bad3_tout", {16'd0, tout_count_o}, 32'd0);

      // Echo on the last allowed WAIT_RESP cycle counts as a response.
      run(1'b1, 1'b0, 100);
      wait_done();
      chk("edge100_pass", {16'd0, pass_count_o}, 32'd4);
      chk("edge100_tout", {16'd0, tout_count_o}, 32'd0);

      // One cycle late: timeout, late echo lands in GAP and is ignored; restart cleared fail count.
      run(1'b1, 1'b0, 101);
      wait_done();
      chk("late_tout", {16'd0, tout_count_o}, 32'd4);
      chk("late_pass", {16'd0, pass_count_o}, 32'd0);
      chk("late_fail", {16'd0, fail_count_o}, 32'd0);

      // No echo, tx_ready stalled 30 cycles.
      tx_ready_i = 1'b0;
      run(1'b0, 1'b0, 50);
      bad_v = 0; bad_d = 0;
      for (int i = 0; i < 30; i++) begin
         if (tx_valid_o !== 1'b1) bad_v++;
         if (tx_data_o !== exp_seq[0]) bad_d++;
         tick();
      end
      chk("stall_valid_held", bad_v, 32'd0);
      chk("stall_data_held", bad_d, 32'd0);
      chk("stall_no_accept", hs_cnt, 32'd0);
      tx_ready_i = 1'b1;
      wait_done();
      chk("noecho_tout", {16'd0, tout_count_o}, 32'd4);
      chk("noecho_hs", hs_cnt, 32'd4);

      // Reset during WAIT_RESP.
      run(1'b1, 1'b0, 50);
      wait_hs(1);
      repeat (10) tick();
      rst_i = 1'b1;
      tick();
      chk("midrst_busy", {31'd0, busy_o}, 32'd0);
      chk("midrst_done", {31'd0, done_o}, 32'd0);
      chk("midrst_tx_valid", {31'd0, tx_valid_o}, 32'd0);
      chk("midrst_last_sent", {24'd0, last_sent_o}, 32'd0);
      rst_i = 1'b0;
      repeat (150) tick();
      chk("midrst_stray_ignored", {16'd0, pass_count_o}, 32'd0);
      chk("midrst_idle", {31'd0, busy_o}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
